dec_key_expansion: RTL and testbench
====================================

// Module: dec_key_expansion
// PURPOSE
//   Iterative AES-128 key schedule for the pipelined decryption datapath; sits upstream of the round stages.
//   Expands a 128-bit cipher key into round keys 0..10, one round key per clock, and holds them in a
//   register bank. Round keys are presented as one flat bus so every pipeline stage has a static key
//   (initial stage uses RK10, rounds 9..1 use RK9..RK1, final stage uses RK0).
//   keys_valid qualifies the bus. The datapath must not accept blocks while keys_valid is low.
// PARAMETERS
//   BLOCK_LENGTH  128  width of the key and of each round key; only 128 is supported.
//   NR            10   number of rounds; only 10 is supported. The bank holds NR+1 round keys.
// PORTS
//   clk         in   1                       clock, rising edge
//   rst         in   1                       asynchronous, active-low reset
//   load        in   1                       single-cycle request to start expansion of KEY
//   KEY         in   BLOCK_LENGTH            cipher key; byte 0 = KEY[127:120]; sampled only on an accepted load
//   busy        out  1                       expansion in progress
//   keys_valid  out  1                       all round keys in RK_ALL are complete and stable
//   RK_ALL      out  (NR+1)*BLOCK_LENGTH     RK_ALL[128*i +: 128] = round key i (i = 0..10)
// BEHAVIOUR
//   Reset (rst=0, asynchronous)
//     - busy=0, keys_valid=0, RK_ALL=0, round counter=0, state=IDLE.
//     - Takes effect immediately, including in the middle of an expansion; no partial result is retained.
//   States
//     - IDLE: no keys. Accepts load.
//     - BUSY: expansion in progress. Ignores load.
//     - READY: keys valid. Accepts load.
//   Accepted load (load=1 in IDLE or READY), edge E0
//     - RK0 <= KEY; cnt <= 1; state <= BUSY; busy <= 1; keys_valid <= 0.
//     - RK1..RK10 keep their old values but are not qualified.
//   BUSY, each edge En (n = 1..10)
//     - RK[cnt] <= f(RK[cnt-1], Rcon[cnt]); cnt <= cnt+1.
//     - At the edge with cnt==10: state <= READY, busy <= 0, keys_valid <= 1.
//     - keys_valid is therefore first high in the cycle after edge E10 (10 cycles after the load edge).
//   Round function f (words w0 = RK[127:96] .. w3 = RK[31:0])
//     - t = SubWord(RotWord(w3)) ^ {Rcon, 24'h0}; RotWord(w) = {w[23:0], w[31:24]}.
//     - SubWord applies the forward AES S-box to each byte (combinational, 4 lookups).
//     - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2. New round key = {n0, n1, n2, n3}.
//     - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. All operations are XOR; there is no carry.
//   Boundaries
//     - load in BUSY: ignored; the expansion in progress is not disturbed.
//     - load in READY: restarts expansion; keys_valid falls at that edge.
//     - load held high for several cycles: only the first edge is accepted; later edges fall in BUSY and are ignored.
//     - KEY changing after the load edge: no effect on the result.
//     - RK_ALL and keys_valid are registered outputs, with no combinational path from the inputs.
// TESTING
//   1. Reset: assert rst=0 mid-sim -> busy=0, keys_valid=0, RK_ALL=0 immediately, before the next clk edge.
//   2. FIPS-197 A.1: load with KEY=2b7e151628aed2a6abf7158809cf4f3c
//      -> RK1=a0fafe1788542cb123a339392a6c7605, RK10=d014f9a8c9ee2589e13f0cc8b6630ca6,
//         keys_valid high exactly 10 cycles after the load edge.
//   3. FIPS-197 C.1: KEY=000102030405060708090a0b0c0d0e0f -> RK10=13111d7fe3944a17f307a78b4d2b30c5, RK0=KEY.
//   4. load pulsed at cycles 3 and 6 after the first load, with a different KEY
//      -> both ignored; final RK_ALL matches the first key.
//   5. Reload in READY with the C.1 key after A.1 completes -> keys_valid drops at the load edge;
//      10 cycles later RK10=13111d7f...
//   6. rst pulsed low at cycle 5 of an expansion -> all outputs cleared; a subsequent load completes correctly.

Source files
------------

// File: rtl/dec_key_expansion.sv
// Iterative AES-128 key schedule for the decryption pipeline.
// One round key per clock into a flat, registered key bank.
module dec_key_expansion #(
  parameter int BLOCK_LENGTH = 128,
  parameter int NR           = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [BLOCK_LENGTH-1:0]          KEY,
  output logic                             busy,
  output logic                             keys_valid,
  output logic [(NR+1)*BLOCK_LENGTH-1:0]   RK_ALL
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] b);
    sb = SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_e                         state_q;
  logic [3:0]                     cnt_q;
  logic                           busy_q;
  logic                           kv_q;
  logic [NR:0][BLOCK_LENGTH-1:0]  rk_q;

  logic [3:0]   prev_idx;
  logic [127:0] prev;
  logic [31:0]  w0, w1, w2, w3, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] rk_d;

  // Next round key from the previous one (RotWord+SubWord+Rcon, XOR chain)
  always_comb begin
    prev_idx = cnt_q - 4'd1;
    prev     = rk_q[prev_idx];
    w0 = prev[127:96];
    w1 = prev[95:64];
    w2 = prev[63:32];
    w3 = prev[31:0];
    t  = {sb(w3[23:16]), sb(w3[15:8]),
          sb(w3[7:0]),   sb(w3[31:24])}
         ^ {rcon(cnt_q), 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    rk_d = {n0, n1, n2, n3};
  end

  // Control FSM and key bank; all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      kv_q    <= 1'b0;
      rk_q    <= '0;
    end else begin
      case (state_q)
        IDLE, READY: begin
          if (load) begin
            rk_q[0] <= KEY;
            cnt_q   <= 4'd1;
            state_q <= BUSY;
            busy_q  <= 1'b1;
            kv_q    <= 1'b0;
          end
        end
        BUSY: begin
          rk_q[cnt_q] <= rk_d;
          cnt_q       <= cnt_q + 4'd1;
          if (cnt_q == 4'(NR)) begin
            state_q <= READY;
            busy_q  <= 1'b0;
            kv_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
          busy_q  <= 1'b0;
          kv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign keys_valid = kv_q;
  assign RK_ALL     = rk_q;

endmodule

// File: tb/tb_dec_key_expansion.sv
// Directed bench for dec_key_expansion.
// FIPS-197 vectors, reload, ignored loads, mid-run reset.
module tb_dec_key_expansion;

  localparam logic [127:0] KA1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1R9 = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] A1RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KC1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [127:0]  KEY = '0;
  logic          busy;
  logic          keys_valid;
  logic [1407:0] RK_ALL;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  dec_key_expansion dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .KEY        (KEY),
    .busy       (busy),
    .keys_valid (keys_valid),
    .RK_ALL     (RK_ALL)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rk(input int i);
    rk = RK_ALL[128*i +: 128];
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive load for one edge; returns just after that edge
  task automatic do_load(input logic [127:0] k);
    @(negedge clk);
    KEY  = k;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Edges after the current point until keys_valid; 0 = timeout
  task automatic wait_kv(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (keys_valid) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    // 1. asynchronous reset, checked before any clock edge
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_kv", 128'(keys_valid), 128'd0);
    chk("rst_rk0", rk(0), 128'd0);
    chk("rst_rk10", rk(10), 128'd0);
    @(negedge clk);
    rst = 1'b1;

    // 2. FIPS-197 A.1; KEY changed right after the load edge
    do_load(KA1);
    KEY = KC1;
    chk("a1_busy", 128'(busy), 128'd1);
    chk("a1_kv0", 128'(keys_valid), 128'd0);
    chk("a1_rk0", rk(0), KA1);
    wait_kv(lat);
    chk("a1_lat", 128'(lat), 128'd10);
    chk("a1_rk1", rk(1), A1R1);
    chk("a1_rk9", rk(9), A1R9);
    chk("a1_rk10", rk(10), A1RA);
    chk("a1_busy_end", 128'(busy), 128'd0);

    // 3/5. reload in READY with the C.1 key
    do_load(KC1);
    chk("rl_kv_drop", 128'(keys_valid), 128'd0);
    chk("rl_busy", 128'(busy), 128'd1);
    chk("rl_rk0", rk(0), KC1);
    wait_kv(lat);
    chk("c1_lat", 128'(lat), 128'd10);
    chk("c1_rk0", rk(0), KC1);
    chk("c1_rk10", rk(10), C1RA);

    // 4. loads at edges 3 and 6 of an expansion are ignored
    do_load(KA1);
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (e == 3 || e == 6) begin
        KEY  = KC1;
        load = 1'b1;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
      if (e == 9)
        chk("ign_kv9", 128'(keys_valid), 128'd0);
    end
    chk("ign_kv", 128'(keys_valid), 128'd1);
    chk("ign_rk0", rk(0), KA1);
    chk("ign_rk1", rk(1), A1R1);
    chk("ign_rk10", rk(10), A1RA);

    // load held high for three edges: only the first counts
    @(negedge clk);
    KEY  = KC1;
    load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    load = 1'b0;
    wait_kv(lat);
    chk("hold_lat", 128'(lat), 128'd8);
    chk("hold_rk10", rk(10), C1RA);

    // 6. reset pulse mid-expansion
    do_load(KA1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mrst_busy", 128'(busy), 128'd0);
    chk("mrst_kv", 128'(keys_valid), 128'd0);
    for (int i = 0; i <= 10; i++)
      chk($sformatf("mrst_rk%0d", i), rk(i), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    do_load(KC1);
    wait_kv(lat);
    chk("post_lat", 128'(lat), 128'd10);
    chk("post_rk0", rk(0), KC1);
    chk("post_rk10", rk(10), C1RA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
